// File: rtl/alu_job_master.sv
// rtl/alu_job_master.sv - host-command driven job master for a memory-mapped ALU slave
module alu_job_master #(
   parameter logic [15:0] OPER_BASE   = 16'h0010,
   parameter logic [15:0] INST_ADDR   = 16'h0008,
   parameter logic [15:0] START_ADDR  = 16'h0000,
   parameter logic [15:0] RESULT_ADDR = 16'h0004,
   parameter logic [15:0] INTCLR_ADDR = 16'h000C,
   parameter int          TIMEOUT     = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [31:0] cmd_data,
   output logic        m_sel,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [31:0] m_dout,
   input  logic [31:0] m_din,
   input  logic        m_interrupt,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [3:0] {
      S_IDLE, S_WRITE, S_START, S_WAIT_INT, S_READ,
      S_CAPTURE, S_OUTPUT, S_CLEAR, S_FINISH
   } state_t;

   localparam logic [1:0]  CMD_OPER  = 2'd0;
   localparam logic [1:0]  CMD_INST  = 2'd1;
   localparam logic [1:0]  CMD_GO    = 2'd2;
   localparam logic [3:0]  INST_MAX  = 4'd8;
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

   state_t      state;
   logic [3:0]  idx;
   logic [3:0]  inst_cnt;
   logic [3:0]  remaining;
   logic [15:0] tmo_cnt;

   // Whole controller: state plus every output is registered. Bus outputs
   // default to zero each cycle so they are only non-zero while m_sel is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b1;
         m_sel     <= 1'b0;
         m_wr      <= 1'b0;
         m_addr    <= '0;
         m_dout    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
         idx       <= '0;
         inst_cnt  <= '0;
         remaining <= '0;
         tmo_cnt   <= '0;
      end else begin
         m_sel  <= 1'b0;
         m_wr   <= 1'b0;
         m_addr <= '0;
         m_dout <= '0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_type)
                     CMD_OPER: begin
                        state     <= S_WRITE;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        m_sel     <= 1'b1;
                        m_wr      <= 1'b1;
                        m_addr    <= OPER_BASE + {12'd0, idx};
                        m_dout    <= cmd_data;
                        idx       <= idx + 4'd1;
                     end
                     CMD_INST: begin
                        if (inst_cnt == INST_MAX) begin
                           // instruction queue full: drop the word, flag it
                           err      <= 1'b1;
                           err_code <= 2'b01;
                        end else begin
                           state     <= S_WRITE;
                           cmd_ready <= 1'b0;
                           busy      <= 1'b1;
                           m_sel     <= 1'b1;
                           m_wr      <= 1'b1;
                           m_addr    <= INST_ADDR;
                           m_dout    <= cmd_data;
                           inst_cnt  <= inst_cnt + 4'd1;
                        end
                     end
                     CMD_GO: begin
                        if (inst_cnt == 4'd0) begin
                           // nothing queued: finish the job without touching the bus
                           done <= 1'b1;
                        end else begin
                           err       <= 1'b0;
                           err_code  <= 2'b00;
                           remaining <= inst_cnt;
                           state     <= S_START;
                           cmd_ready <= 1'b0;
                           busy      <= 1'b1;
                           m_sel     <= 1'b1;
                           m_wr      <= 1'b1;
                           m_addr    <= START_ADDR;
                           m_dout    <= 32'h1;
                        end
                     end
                     default: begin
                        // reserved command type is swallowed
                     end
                  endcase
               end
            end
            S_WRITE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            S_START: begin
               state   <= S_WAIT_INT;
               tmo_cnt <= '0;
            end
            S_WAIT_INT: begin
               if (m_interrupt) begin
                  state  <= S_READ;
                  m_sel  <= 1'b1;
                  m_addr <= RESULT_ADDR;
               end else if (tmo_cnt == TMO_LAST) begin
                  state    <= S_FINISH;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  err_code <= 2'b10;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            S_READ: begin
               // slave presents read data one cycle after the read strobe
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               res_data  <= m_din;
               res_valid <= 1'b1;
               state     <= S_OUTPUT;
            end
            S_OUTPUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  remaining <= remaining - 4'd1;
                  if (remaining > 4'd1) begin
                     state  <= S_READ;
                     m_sel  <= 1'b1;
                     m_addr <= RESULT_ADDR;
                  end else begin
                     state  <= S_CLEAR;
                     m_sel  <= 1'b1;
                     m_wr   <= 1'b1;
                     m_addr <= INTCLR_ADDR;
                     m_dout <= 32'h1;
                  end
               end
            end
            S_CLEAR: begin
               state <= S_FINISH;
               done  <= 1'b1;
            end
            S_FINISH: begin
               idx       <= '0;
               inst_cnt  <= '0;
               remaining <= '0;
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_job_master.sv
// tb/tb_alu_job_master.sv - directed self-checking bench for alu_job_master
module tb_alu_job_master;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_type = 2'd0;
   logic [31:0] cmd_data = '0;
   logic        m_sel;
   logic        m_wr;
   logic [15:0] m_addr;
   logic [31:0] m_dout;
   logic [31:0] m_din = '0;
   logic        m_interrupt = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int checks = 0;
   int failures = 0;
   int rd_count = 0;
   int rd_base = 0;
   int n_done = 0;
   int n_res = 0;
   int bus_err = 0;
   logic [31:0] res_log [64];

   alu_job_master #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_data(cmd_data),
      .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
      .m_interrupt(m_interrupt),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // ALU slave: result reads return 0x17, 0x18, ... counted from rd_base
   always @(posedge clk) begin
      if (m_sel && !m_wr && m_addr == 16'h0004) begin
         m_din    <= 32'h17 + 32'(rd_count - rd_base);
         rd_count <= rd_count + 1;
      end
   end

   // delivered results
   always @(posedge clk) begin
      if (!reset && res_valid && res_ready) begin
         if (n_res < 64) res_log[n_res] <= res_data;
         n_res <= n_res + 1;
      end
   end

   // done pulses and idle-bus cleanliness
   always @(negedge clk) begin
      if (done) n_done <= n_done + 1;
      if (!m_sel && (m_wr || m_addr != 16'h0 || m_dout != 32'h0)) bus_err <= bus_err + 1;
   end

   typedef struct packed {
      logic [1:0]  t;
      logic [31:0] d;
      logic        bus;
      logic [15:0] addr;
      logic        err;
      logic [1:0]  code;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] t, input logic [31:0] d);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 1);
      cmd_type  = t;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_type  = 2'd0;
      cmd_data  = '0;
   endtask

   task automatic cmd_bus(input string nm, input logic [1:0] t, input logic [31:0] d,
                          input logic [15:0] a);
      send_cmd(t, d);
      @(negedge clk);
      chk({nm, "_sel"},  32'(m_sel), 1);
      chk({nm, "_wr"},   32'(m_wr), 1);
      chk({nm, "_addr"}, 32'(m_addr), 32'(a));
      chk({nm, "_dout"}, m_dout, d);
      @(negedge clk);
      chk({nm, "_ready"}, 32'(cmd_ready), 1);
   endtask

   task automatic wait_done(input int max, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < max);
      if (!done) chk("done_timeout", 32'(done), 1);
   endtask

   task automatic pulse_irq();
      m_interrupt = 1'b1;
      @(posedge clk);
      #1;
      m_interrupt = 1'b0;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_cmd_ready"}, 32'(cmd_ready), 1);
      chk({nm, "_m_sel"},     32'(m_sel), 0);
      chk({nm, "_m_addr"},    32'(m_addr), 0);
      chk({nm, "_busy"},      32'(busy), 0);
      chk({nm, "_done"},      32'(done), 0);
      chk({nm, "_res_valid"}, 32'(res_valid), 0);
      chk({nm, "_err"},       32'(err), 0);
      chk({nm, "_err_code"},  32'(err_code), 0);
   endtask

   initial begin
      int cyc;
      int nd0;
      int nr0;

      vecs[0]  = '{2'd0, 32'h0000_000A, 1'b1, 16'h0010, 1'b0, 2'd0};
      vecs[1]  = '{2'd0, 32'h0000_000B, 1'b1, 16'h0011, 1'b0, 2'd0};
      vecs[2]  = '{2'd0, 32'h0000_000C, 1'b1, 16'h0012, 1'b0, 2'd0};
      vecs[3]  = '{2'd3, 32'h0000_DEAD, 1'b0, 16'h0000, 1'b0, 2'd0};
      for (int i = 0; i < 8; i++)
         vecs[4 + i] = '{2'd1, 32'h100 + 32'(i), 1'b1, 16'h0008, 1'b0, 2'd0};
      vecs[12] = '{2'd1, 32'h0000_0108, 1'b0, 16'h0000, 1'b1, 2'd1};
      vecs[13] = '{2'd0, 32'h0000_000D, 1'b1, 16'h0013, 1'b1, 2'd1};

      // asynchronous reset takes effect before any clock edge
      #2 reset = 1'b1;
      #1 chk_reset_vals("por");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // interrupt while idle is ignored
      m_interrupt = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_interrupt = 1'b0;
      chk("irq_idle_busy", 32'(busy), 0);
      chk("irq_idle_sel", 32'(m_sel), 0);
      chk("irq_idle_ready", 32'(cmd_ready), 1);

      // table: operands, reserved type, eight instructions, overflow, sticky err
      for (int i = 0; i < 14; i++) begin
         send_cmd(vecs[i].t, vecs[i].d);
         @(negedge clk);
         chk($sformatf("v%0d_sel", i), 32'(m_sel), 32'(vecs[i].bus));
         chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(!vecs[i].bus));
         if (vecs[i].bus) begin
            chk($sformatf("v%0d_wr", i), 32'(m_wr), 1);
            chk($sformatf("v%0d_addr", i), 32'(m_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_dout", i), m_dout, vecs[i].d);
         end
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
         chk($sformatf("v%0d_code", i), 32'(err_code), 32'(vecs[i].code));
         @(negedge clk);
         chk($sformatf("v%0d_ready2", i), 32'(cmd_ready), 1);
         chk($sformatf("v%0d_sel2", i), 32'(m_sel), 0);
      end

      // go with 8 queued clears err; no interrupt -> timeout after 16 wait cycles
      rd_base = rd_count;
      nd0 = n_done;
      send_cmd(2'd2, 32'h0);
      @(negedge clk);
      chk("go_start_sel", 32'(m_sel), 1);
      chk("go_start_addr", 32'(m_addr), 32'h0000);
      chk("go_start_dout", m_dout, 32'h1);
      chk("go_err_cleared", 32'(err), 0);
      chk("go_code_cleared", 32'(err_code), 0);
      wait_done(60, cyc);
      chk("tmo_wait_cycles", 32'(cyc - 1), 16);
      chk("tmo_err", 32'(err), 1);
      chk("tmo_code", 32'(err_code), 2);
      chk("tmo_no_read", 32'(rd_count - rd_base), 0);
      @(negedge clk);
      chk("tmo_done_count", 32'(n_done - nd0), 1);
      chk("tmo_idle_ready", 32'(cmd_ready), 1);
      chk("tmo_idle_busy", 32'(busy), 0);

      // basic job: three operands, one instruction, one result
      cmd_bus("j1_op0", 2'd0, 32'hA, 16'h0010);
      cmd_bus("j1_op1", 2'd0, 32'hB, 16'h0011);
      cmd_bus("j1_op2", 2'd0, 32'hC, 16'h0012);
      cmd_bus("j1_inst", 2'd1, 32'h1234, 16'h0008);
      rd_base = rd_count;
      nd0 = n_done;
      nr0 = n_res;
      send_cmd(2'd2, 32'h0);
      @(negedge clk);
      chk("j1_start_addr", 32'(m_addr), 32'h0000);
      chk("j1_start_dout", m_dout, 32'h1);
      chk("j1_busy", 32'(busy), 1);
      repeat (5) @(negedge clk);
      pulse_irq();
      @(negedge clk);
      chk("j1_read_sel", 32'(m_sel), 1);
      chk("j1_read_wr", 32'(m_wr), 0);
      chk("j1_read_addr", 32'(m_addr), 32'h0004);
      @(negedge clk);
      chk("j1_capture_valid", 32'(res_valid), 0);
      @(negedge clk);
      chk("j1_res_valid", 32'(res_valid), 1);
      chk("j1_res_data", res_data, 32'h17);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk("j1_clr_sel", 32'(m_sel), 1);
      chk("j1_clr_wr", 32'(m_wr), 1);
      chk("j1_clr_addr", 32'(m_addr), 32'h000C);
      chk("j1_clr_dout", m_dout, 32'h1);
      chk("j1_valid_dropped", 32'(res_valid), 0);
      @(negedge clk);
      chk("j1_done", 32'(done), 1);
      @(negedge clk);
      chk("j1_done_once", 32'(n_done - nd0), 1);
      chk("j1_reads", 32'(rd_count - rd_base), 1);
      chk("j1_results", 32'(n_res - nr0), 1);
      chk("j1_idle_ready", 32'(cmd_ready), 1);

      // seventeen operands: idx wraps so the 17th lands on 0x10
      for (int k = 0; k < 17; k++)
         cmd_bus($sformatf("wrap%0d", k), 2'd0, 32'h500 + 32'(k), 16'h0010 + 16'(k % 16));

      // two instructions with back-pressure on the result port
      cmd_bus("bp_inst0", 2'd1, 32'h21, 16'h0008);
      cmd_bus("bp_inst1", 2'd1, 32'h22, 16'h0008);
      rd_base = rd_count;
      nr0 = n_res;
      send_cmd(2'd2, 32'h0);
      @(negedge clk);
      @(negedge clk);
      pulse_irq();
      repeat (3) @(negedge clk);
      chk("bp_valid", 32'(res_valid), 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_valid%0d", c), 32'(res_valid), 1);
         chk($sformatf("bp_hold_data%0d", c), res_data, 32'h17);
         chk($sformatf("bp_hold_reads%0d", c), 32'(rd_count - rd_base), 1);
      end
      res_ready = 1'b1;
      wait_done(60, cyc);
      res_ready = 1'b0;
      chk("bp_results", 32'(n_res - nr0), 2);
      chk("bp_reads", 32'(rd_count - rd_base), 2);
      chk("bp_res0", res_log[nr0], 32'h17);
      chk("bp_res1", res_log[nr0 + 1], 32'h18);
      @(negedge clk);

      // reset during WAIT_INT aborts the job
      cmd_bus("rst_inst", 2'd1, 32'h33, 16'h0008);
      nd0 = n_done;
      nr0 = n_res;
      send_cmd(2'd2, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy_before", 32'(busy), 1);
      #2 reset = 1'b1;
      #1 chk_reset_vals("mid");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("post");
      chk("rst_no_done", 32'(n_done - nd0), 0);
      chk("rst_no_result", 32'(n_res - nr0), 0);
      send_cmd(2'd2, 32'h0);
      @(negedge clk);
      chk("rst_go_done", 32'(done), 1);
      chk("rst_go_no_bus", 32'(m_sel), 0);
      chk("rst_go_idle", 32'(cmd_ready), 1);
      @(negedge clk);
      chk("rst_go_done_pulse", 32'(done), 0);

      chk("bus_idle_zero", 32'(bus_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
